// File: rtl/score_keeper.sv
// Game-state FSM and saturating BCD scorer downstream of the collision checker.
// Optional best-score register enabled by defining SCORE_KEEPER_BEST_EN.
module score_keeper #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                point,
    input  logic                gameover,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] best,
    output logic                running,
    output logic                over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic                point_q, start_q;
    logic                running_q, running_d;
    logic                over_q, over_d;
    logic                point_ev_s, start_ev_s;

    // All-9s saturates; otherwise ripple a decimal carry through the digits.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        logic                all9;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                all9 = 1'b0;
            end
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return all9 ? v : r;
    endfunction

    assign point_ev_s = point & ~point_q;
    assign start_ev_s = start & ~start_q;

    // State register, score and edge-detect samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            point_q   <= 1'b0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            point_q   <= point;
            start_q   <= start;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    // Next-state and score update.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                if (start_ev_s) begin
                    state_d = PLAY;
                    score_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (gameover) begin
                    state_d = OVER;
                end else if (point_ev_s) begin
                    score_d = bcd_inc(score_q);
                end else begin
                    score_d = score_q;
                end
            end
            OVER: begin
                if (start_ev_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OVER;
                end
            end
            default: begin
                state_d = IDLE;
                score_d = '0;
            end
        endcase
    end

    // Status flags decoded from the next state so they land with the state flop.
    always_comb begin
        running_d = 1'b0;
        over_d    = 1'b0;
        case (state_d)
            PLAY:    running_d = 1'b1;
            OVER:    over_d    = 1'b1;
            default: begin
                running_d = 1'b0;
                over_d    = 1'b0;
            end
        endcase
    end

`ifdef SCORE_KEEPER_BEST_EN
    logic [4*DIGITS-1:0] best_q, best_d;

    // Packed BCD compares correctly as plain unsigned.
    always_comb begin
        if ((state_q == PLAY) && gameover && (score_q > best_q)) begin
            best_d = score_q;
        end else begin
            best_d = best_q;
        end
    end

    // Best-score register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
`else
    assign best = '0;
`endif

    assign score   = score_q;
    assign running = running_q;
    assign over    = over_q;

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-state and scoring stage directly downstream of the collision checker in the LED-matrix game. Consumes that checker's registered `point` and `gameover` levels, runs the IDLE/PLAY/OVER game state machine, and keeps a saturating BCD score plus an optional best score for the HEX display drivers. `running` gates the obstacle scroller; `over` drives the game-over display.

## Interface
- `DIGITS`, default 2: number of BCD digits for `score` and `best`. Maximum score is all 9s.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 means reset.
- `start`  in  1  player start button, already synchronized, level.
- `point`  in  1  level from the collision checker. High while the player column is occupied without collision.
- `gameover`  in  1  level from the collision checker. High on collision.
- `score`  out  4*DIGITS  current score, BCD. Digit 0 is in bits [3:0].
- `best`  out  4*DIGITS  best score, BCD.
- `running`  out  1  high in PLAY.
- `over`  out  1  high in OVER.

## Operation
- Internal edge registers `point_q` and `start_q` sample their inputs every cycle in every state.
  - Point event: `point & ~point_q`.
  - Start event: `start & ~start_q`.
  - A level held high counts exactly once.
- States: IDLE, PLAY, OVER. Encoding is free.
- IDLE:
  - Outputs: `running`=0, `over`=0. `score` holds its last value.
  - A start event moves to PLAY and clears `score` to 0 on the same edge.
- PLAY:
  - Outputs: `running`=1.
  - `gameover`=1 moves to OVER. There is no increment on that edge, even if a point event occurs simultaneously.
  - Otherwise, a point event increments `score` by 1.
  - Start events are ignored.
- OVER:
  - Outputs: `over`=1, `score` frozen.
  - A start event moves to IDLE.
  - `point` and `gameover` are ignored.
- If `point` is already high on PLAY entry, it does not count. Only a fresh 0→1 transition counts.
- BCD increment rules:
  - A digit at 9 wraps to 0 and carries into the next digit.
  - At all-9s the score saturates and stays all-9s; there is no wrap to 0.
  - Digits never hold values 10–15.
- Reset (asynchronous, any time, including mid-game):
  - State = IDLE.
  - `score`, `best`, `point_q`, `start_q` = 0.
  - Outputs: `running`=0, `over`=0.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- `score` changes on the first rising edge at which `point`=1 and `point_q`=0 are sampled, and is visible after that edge. Latency is 1 cycle from `point` rising.
- `over` rises and `running` falls on the first edge sampling `gameover`=1 in PLAY. Latency is 1 cycle.
- `best` (when enabled) updates on the same edge as the PLAY→OVER transition. It is visible together with `over`=1.
- The start-event to PLAY transition takes 1 cycle. Consecutive start events need `start` to return to 0 for at least 1 cycle.

## Configuration
- `SCORE_KEEPER_BEST_EN` defined:
  - On the PLAY→OVER edge, `best` loads `score` if `score` > `best`.
  - The comparison is unsigned over the packed BCD vector, which preserves BCD ordering.
  - `best` is cleared only by reset, never by start.
- `SCORE_KEEPER_BEST_EN` not defined:
  - `best` is constant 0.
  - No best register or comparator is synthesized.

## Test plan
- Reset then release, no stimulus: state IDLE, `score`=00, `best`=00, `running`=0, `over`=0. Assert `reset`=0 mid-PLAY with `score`=07: all outputs return to 0 immediately, before the next clock edge.
- `start` pulse, then 3 separate `point` pulses each 1 cycle high, then one `point` held high for 5 cycles: `running`=1 and `score`=04. Each increment appears 1 cycle after its `point` rises.
- In PLAY with `score`=12, raise `point` and `gameover` on the same cycle: next cycle `over`=1, `running`=0, `score`=12. With the macro defined, `best`=12.
- Saturation with DIGITS=2: drive 101 point pulses: `score` passes 09→10 correctly and ends at 99, not 00.
- Start in OVER moves to IDLE with `score` held. The next start clears `score`=00.
  - Game ending with `score`=05 after `best`=12: `best` stays 12.
  - With the macro undefined: `best`=00 throughout.
- Start held high for 10 cycles from IDLE: exactly one IDLE→PLAY transition. A `point` already high at PLAY entry does not increment.
